// File: rtl/ram_writeback_bridge.sv
`default_nettype none
// ============================================================================
// Module  : ram_writeback_bridge
// Brief   : Routes butterfly result pairs to even/odd RAM banks, undoing the
//           read-side corner turn; optional RAM_WRITEBACK_SCALE_EN halves data.
// Rev     : 1.0  initial release
// ============================================================================
module ram_writeback_bridge #(
    parameter int FFT_N  = 10,
    parameter int FFT_DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iact,
    input  logic [1:0]            ictrl,
    input  logic [FFT_N-2:0]      iMemAddr,
    input  logic [2*FFT_DW-1:0]   iDataA,
    input  logic [2*FFT_DW-1:0]   iDataB,
    output logic                  oEvenWe,
    output logic [FFT_N-2:0]      oEvenAddr,
    output logic [2*FFT_DW-1:0]   oEvenData,
    output logic                  oOddWe,
    output logic [FFT_N-2:0]      oOddAddr,
    output logic [2*FFT_DW-1:0]   oOddData,
    output logic                  oStageDone,
    output logic                  oerr
);

    localparam int AW = FFT_N - 1;
    localparam int WW = 2 * FFT_DW;
    localparam int CW = FFT_N + 1;

    localparam logic [1:0]    C_CTRL_FIRST = 2'b10;
    localparam logic [1:0]    C_CTRL_EVEN  = 2'b00;
    localparam logic [1:0]    C_CTRL_ODD   = 2'b11;
    localparam logic [CW-1:0] C_FRAME      = {1'b1, {FFT_N{1'b0}}};

`ifdef RAM_WRITEBACK_SCALE_EN
    // (x + 1) >>> 1 at FFT_DW+1 bits, truncated: bits [FFT_DW:1] of the sum.
    function automatic logic [WW-1:0] f_scale(input logic [WW-1:0] w);
        logic [FFT_DW:0] re;
        logic [FFT_DW:0] im;
        re = {w[WW-1], w[WW-1:FFT_DW]} + {{FFT_DW{1'b0}}, 1'b1};
        im = {w[FFT_DW-1], w[FFT_DW-1:0]} + {{FFT_DW{1'b0}}, 1'b1};
        return {re[FFT_DW:1], im[FFT_DW:1]};
    endfunction
`else
    function automatic logic [WW-1:0] f_scale(input logic [WW-1:0] w);
        return w;
    endfunction
`endif

    // Stage 1: input capture
    logic          act_q;
    logic [1:0]    ctrl_q;
    logic [AW-1:0] addr_s1_q;
    logic [WW-1:0] a_s1_q;
    logic [WW-1:0] b_s1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            act_q  <= iact;
            ctrl_q <= ictrl;
        end
    end

    always_ff @(posedge clk) begin
        addr_s1_q <= iMemAddr;
        a_s1_q    <= f_scale(iDataA);
        b_s1_q    <= f_scale(iDataB);
    end

    // Stage 2: write stage
    logic          even_we_q,    even_we_d;
    logic [AW-1:0] even_addr_q,  even_addr_d;
    logic [WW-1:0] even_data_q,  even_data_d;
    logic          odd_we_q,     odd_we_d;
    logic [AW-1:0] odd_addr_q,   odd_addr_d;
    logic [WW-1:0] odd_data_q,   odd_data_d;
    logic          hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_addr_q,  hold_addr_d;
    logic [WW-1:0] hold_data_q,  hold_data_d;
    logic          flush_valid_q, flush_valid_d;
    logic [AW-1:0] flush_addr_q, flush_addr_d;
    logic [WW-1:0] flush_data_q, flush_data_d;
    logic          done_q,       done_d;
    logic          err_q,        err_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [CW-1:0] w_sum;
    logic          w_is_odd;

    always_comb begin
        even_we_d     = 1'b0;
        even_addr_d   = even_addr_q;
        even_data_d   = even_data_q;
        odd_we_d      = 1'b0;
        odd_addr_d    = odd_addr_q;
        odd_data_d    = odd_data_q;
        hold_valid_d  = 1'b0;
        hold_addr_d   = hold_addr_q;
        hold_data_d   = hold_data_q;
        flush_valid_d = 1'b0;
        flush_addr_d  = flush_addr_q;
        flush_data_d  = flush_data_q;
        err_d         = err_q;
        w_is_odd      = act_q && (ctrl_q == C_CTRL_ODD);

        // A pending flush always owns the odd port this cycle.
        if (flush_valid_q) begin
            odd_we_d   = 1'b1;
            odd_addr_d = flush_addr_q;
            odd_data_d = flush_data_q;
        end

        if (hold_valid_q && !w_is_odd) begin
            err_d = 1'b1;
        end

        if (act_q) begin
            case (ctrl_q)
                C_CTRL_FIRST: begin
                    even_we_d   = 1'b1;
                    even_addr_d = addr_s1_q;
                    even_data_d = a_s1_q;
                    if (flush_valid_q) begin
                        err_d = 1'b1;
                    end else begin
                        odd_we_d   = 1'b1;
                        odd_addr_d = addr_s1_q;
                        odd_data_d = b_s1_q;
                    end
                end
                C_CTRL_EVEN: begin
                    even_we_d    = 1'b1;
                    even_addr_d  = addr_s1_q;
                    even_data_d  = a_s1_q;
                    hold_valid_d = 1'b1;
                    hold_addr_d  = addr_s1_q;
                    hold_data_d  = b_s1_q;
                end
                C_CTRL_ODD: begin
                    if (hold_valid_q) begin
                        even_we_d     = 1'b1;
                        even_addr_d   = addr_s1_q;
                        even_data_d   = hold_data_q;
                        odd_we_d      = 1'b1;
                        odd_addr_d    = hold_addr_q;
                        odd_data_d    = a_s1_q;
                        flush_valid_d = 1'b1;
                        flush_addr_d  = addr_s1_q;
                        flush_data_d  = b_s1_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end

        // Counter tracks the writes being registered this cycle so the pulse
        // lines up with the frame-completing write.
        w_sum  = cnt_q + {{(CW-1){1'b0}}, even_we_d} + {{(CW-1){1'b0}}, odd_we_d};
        done_d = (w_sum >= C_FRAME);
        cnt_d  = done_d ? (w_sum - C_FRAME) : w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            even_we_q     <= 1'b0;
            odd_we_q      <= 1'b0;
            hold_valid_q  <= 1'b0;
            flush_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            even_we_q     <= even_we_d;
            odd_we_q      <= odd_we_d;
            hold_valid_q  <= hold_valid_d;
            flush_valid_q <= flush_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        even_addr_q  <= even_addr_d;
        even_data_q  <= even_data_d;
        odd_addr_q   <= odd_addr_d;
        odd_data_q   <= odd_data_d;
        hold_addr_q  <= hold_addr_d;
        hold_data_q  <= hold_data_d;
        flush_addr_q <= flush_addr_d;
        flush_data_q <= flush_data_d;
    end

    assign oEvenWe    = even_we_q;
    assign oEvenAddr  = even_addr_q;
    assign oEvenData  = even_data_q;
    assign oOddWe     = odd_we_q;
    assign oOddAddr   = odd_addr_q;
    assign oOddData   = odd_data_q;
    assign oStageDone = done_q;
    assign oerr       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_writeback_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_writeback_bridge
// Brief   : Directed and random stimulus against a write-schedule reference.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ram_writeback_bridge;

    localparam int FFT_N  = 4;
    localparam int FFT_DW = 16;
    localparam int AW     = FFT_N - 1;
    localparam int WW     = 2 * FFT_DW;
    localparam int MAXC   = 64;
    localparam int TAIL   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iact = 1'b0;
    logic [1:0]    ictrl = 2'b00;
    logic [AW-1:0] iMemAddr = '0;
    logic [WW-1:0] iDataA = '0;
    logic [WW-1:0] iDataB = '0;
    logic          oEvenWe, oOddWe, oStageDone, oerr;
    logic [AW-1:0] oEvenAddr, oOddAddr;
    logic [WW-1:0] oEvenData, oOddData;

    ram_writeback_bridge #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) dut (
        .clk(clk), .rst(rst), .iact(iact), .ictrl(ictrl), .iMemAddr(iMemAddr),
        .iDataA(iDataA), .iDataB(iDataB),
        .oEvenWe(oEvenWe), .oEvenAddr(oEvenAddr), .oEvenData(oEvenData),
        .oOddWe(oOddWe), .oOddAddr(oOddAddr), .oOddData(oOddData),
        .oStageDone(oStageDone), .oerr(oerr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Stimulus table
    logic          in_act  [MAXC];
    logic [1:0]    in_ctrl [MAXC];
    logic [AW-1:0] in_addr [MAXC];
    logic [WW-1:0] in_a    [MAXC];
    logic [WW-1:0] in_b    [MAXC];

    // Expected per-cycle outputs
    logic          e_ew [MAXC];
    logic [AW-1:0] e_ea [MAXC];
    logic [WW-1:0] e_ed [MAXC];
    logic          e_ow [MAXC];
    logic [AW-1:0] e_oa [MAXC];
    logic [WW-1:0] e_od [MAXC];
    logic          e_done [MAXC];
    logic          e_err  [MAXC];
    logic          err_ev [MAXC];

    function automatic logic [WW-1:0] model_scale(input logic [WW-1:0] w);
`ifdef RAM_WRITEBACK_SCALE_EN
        int re, im;
        re = int'($signed(w[WW-1:FFT_DW]));
        im = int'($signed(w[FFT_DW-1:0]));
        re = (re + 1) >>> 1;
        im = (im + 1) >>> 1;
        return {re[FFT_DW-1:0], im[FFT_DW-1:0]};
`else
        return w;
`endif
    endfunction

    // Reference: each input at cycle t schedules bank writes at t+2 (and t+3
    // for the deferred odd word), then a frame counter runs over the schedule.
    task automatic build_model(input int len);
        bit            hv;
        logic [AW-1:0] ha;
        logic [WW-1:0] hb, a, b;
        int            words;
        bit            sticky;
        hv = 0; ha = '0; hb = '0;
        for (int c = 0; c < MAXC; c++) begin
            e_ew[c] = 0; e_ow[c] = 0; e_ea[c] = '0; e_oa[c] = '0;
            e_ed[c] = '0; e_od[c] = '0; err_ev[c] = 0;
        end
        for (int t = 0; t < len; t++) begin
            a = model_scale(in_a[t]);
            b = model_scale(in_b[t]);
            if (hv && !(in_act[t] && in_ctrl[t] == 2'b11)) begin
                err_ev[t+2] = 1;
                hv = 0;
            end
            if (in_act[t]) begin
                case (in_ctrl[t])
                    2'b10: begin
                        e_ew[t+2] = 1; e_ea[t+2] = in_addr[t]; e_ed[t+2] = a;
                        if (e_ow[t+2]) err_ev[t+2] = 1;
                        else begin e_ow[t+2] = 1; e_oa[t+2] = in_addr[t]; e_od[t+2] = b; end
                    end
                    2'b00: begin
                        e_ew[t+2] = 1; e_ea[t+2] = in_addr[t]; e_ed[t+2] = a;
                        hv = 1; ha = in_addr[t]; hb = b;
                    end
                    2'b11: begin
                        if (hv) begin
                            e_ew[t+2] = 1; e_ea[t+2] = in_addr[t]; e_ed[t+2] = hb;
                            e_ow[t+2] = 1; e_oa[t+2] = ha;         e_od[t+2] = a;
                            e_ow[t+3] = 1; e_oa[t+3] = in_addr[t]; e_od[t+3] = b;
                            hv = 0;
                        end else err_ev[t+2] = 1;
                    end
                    default: err_ev[t+2] = 1;
                endcase
            end
        end
        words = 0; sticky = 0;
        for (int c = 0; c < MAXC; c++) begin
            words += int'(e_ew[c]) + int'(e_ow[c]);
            e_done[c] = (words >= (1 << FFT_N));
            if (e_done[c]) words -= (1 << FFT_N);
            sticky |= err_ev[c];
            e_err[c] = sticky;
        end
    endtask

    task automatic apply_reset();
        rst = 1; iact = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic check_cycle(input string sc, input int t);
        chk($sformatf("%s c%0d even_we", sc, t), 64'(oEvenWe), 64'(e_ew[t]));
        chk($sformatf("%s c%0d odd_we", sc, t), 64'(oOddWe), 64'(e_ow[t]));
        chk($sformatf("%s c%0d done", sc, t), 64'(oStageDone), 64'(e_done[t]));
        chk($sformatf("%s c%0d err", sc, t), 64'(oerr), 64'(e_err[t]));
        if (e_ew[t]) begin
            chk($sformatf("%s c%0d even_addr", sc, t), 64'(oEvenAddr), 64'(e_ea[t]));
            chk($sformatf("%s c%0d even_data", sc, t), 64'(oEvenData), 64'(e_ed[t]));
        end
        if (e_ow[t]) begin
            chk($sformatf("%s c%0d odd_addr", sc, t), 64'(oOddAddr), 64'(e_oa[t]));
            chk($sformatf("%s c%0d odd_data", sc, t), 64'(oOddData), 64'(e_od[t]));
        end
    endtask

    task automatic run(input string sc, input int len, input bit do_reset);
        if (do_reset) apply_reset();
        build_model(len);
        for (int t = 0; t < len + TAIL; t++) begin
            check_cycle(sc, t);
            if (t < len) begin
                iact = in_act[t]; ictrl = in_ctrl[t]; iMemAddr = in_addr[t];
                iDataA = in_a[t]; iDataB = in_b[t];
            end else begin
                iact = 0; ictrl = 2'b01;
                iDataA = WW'($urandom); iDataB = WW'($urandom);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input int t, input logic act, input logic [1:0] ctrl,
                          input logic [AW-1:0] addr, input logic [WW-1:0] a,
                          input logic [WW-1:0] b);
        in_act[t] = act; in_ctrl[t] = ctrl; in_addr[t] = addr; in_a[t] = a; in_b[t] = b;
    endtask

    task automatic load_frame();
        for (int k = 0; k < 8; k++)
            set_in(k, 1, 2'b10, AW'(k), 32'h000A_0000 | k, 32'h000B_0000 | k);
    endtask

    initial begin
        bit prev00;
        int r;

        load_frame();
        run("frame", 8, 1);

        set_in(0, 1, 2'b00, 3'd2, 32'h11, 32'h22);
        set_in(1, 1, 2'b11, 3'd5, 32'h33, 32'h44);
        run("pair", 2, 1);

        set_in(0, 1, 2'b11, 3'd4, 32'h55, 32'h66);
        set_in(1, 0, 2'b00, 3'd0, 32'h0, 32'h0);
        set_in(2, 1, 2'b10, 3'd1, 32'h77, 32'h88);
        run("orphan11", 3, 1);

        set_in(0, 1, 2'b00, 3'd1, 32'hA0, 32'hB0);
        set_in(1, 1, 2'b11, 3'd6, 32'hA1, 32'hB1);
        set_in(2, 1, 2'b10, 3'd3, 32'hC0, 32'hC1);
        run("flushwin", 3, 1);

        set_in(0, 1, 2'b10, 3'd0, 32'h0003_FFFD, 32'h7FFF_7FFF);
        set_in(1, 1, 2'b01, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        run("scale", 2, 1);

        // Reset lands while a 00 sits in the pipeline; nothing of it may emerge.
        apply_reset();
        iact = 1; ictrl = 2'b00; iMemAddr = 3'd2; iDataA = 32'h11; iDataB = 32'h22;
        @(posedge clk); #1;
        rst = 1; iact = 0;
        @(posedge clk); #1;
        rst = 0;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("rstmid c%0d even_we", t), 64'(oEvenWe), 64'(0));
            chk($sformatf("rstmid c%0d odd_we", t), 64'(oOddWe), 64'(0));
            chk($sformatf("rstmid c%0d done", t), 64'(oStageDone), 64'(0));
            chk($sformatf("rstmid c%0d err", t), 64'(oerr), 64'(0));
            @(posedge clk); #1;
        end
        load_frame();
        run("postrst", 8, 0);

        for (int s = 0; s < 4; s++) begin
            prev00 = 0;
            for (int t = 0; t < 40; t++) begin
                r = int'($urandom_range(0, 9));
                in_act[t]  = ($urandom_range(0, 7) != 0);
                if (prev00 && r < 8) in_ctrl[t] = 2'b11;
                else if (r < 4)     in_ctrl[t] = 2'b10;
                else if (r < 8)     in_ctrl[t] = 2'b00;
                else if (r < 9)     in_ctrl[t] = 2'b11;
                else                in_ctrl[t] = 2'b01;
                in_addr[t] = AW'($urandom);
                in_a[t]    = WW'($urandom);
                in_b[t]    = WW'($urandom);
                prev00 = in_act[t] && (in_ctrl[t] == 2'b00);
            end
            run($sformatf("rand%0d", s), 40, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
